// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_pkg
//  Purpose  : Shared types and constants for the multi-cycle data-memory
//             responder (FSM state encoding, operation encoding, word size).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  localparam int WORD_BYTES  = 4;
  // Number of byte-offset bits inside one word.
  localparam int OFFSET_BITS = $clog2(WORD_BYTES);

endpackage
`default_nettype wire

// File: rtl/d_mem_resp_if.sv
`default_nettype none
// ============================================================================
//  Module   : d_mem_resp_if
//  Purpose  : MEM-stage request/response bundle between the pipeline and the
//             data-memory responder.
//  Ports    : memread, memwrite, addr, write_data   (request, from master)
//             read_data, stall, done, misaligned    (response, from slave)
//  Revision : 1.0  initial release
// ============================================================================
interface d_mem_resp_if;

  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        stall;
  logic        done;
  logic        misaligned;

  modport master (
    output memread, memwrite, addr, write_data,
    input  read_data, stall, done, misaligned
  );

  modport slave (
    input  memread, memwrite, addr, write_data,
    output read_data, stall, done, misaligned
  );

endinterface
`default_nettype wire

// File: rtl/d_mem_array.sv
`default_nettype none
// ============================================================================
//  Module   : d_mem_array
//  Purpose  : Synchronous single-port RAM with write enable and a registered
//             read port that only updates on a read enable.
//  Ports    : clk, rst            clock / sync active-high reset (read reg only)
//             we, re              write / read enables
//             idx                 word index
//             wdata               write data
//             rdata               registered read data (holds between reads)
//  Revision : 1.0  initial release
// ============================================================================
module d_mem_array #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] idx,
  input  logic [DATA_BITS-1:0] wdata,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule
`default_nettype wire

// File: rtl/d_mem_resp.sv
`default_nettype none
// ============================================================================
//  Module   : d_mem_resp
//  Purpose  : Multi-cycle data-memory responder. Captures one MEM-stage
//             request, stalls the pipeline for LATENCY cycles, then performs
//             the word access and pulses done for one cycle.
//  Ports    : clk, rst  clock / synchronous active-high reset
//             bus       d_mem_resp_if.slave (memread, memwrite, addr,
//                       write_data in; read_data, stall, done, misaligned out)
//  Revision : 1.0  initial release
// ============================================================================
module d_mem_resp
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 3
) (
  input  logic         clk,
  input  logic         rst,
  d_mem_resp_if.slave  bus
);

  localparam int       CAP_BITS    = ADDR_BITS + OFFSET_BITS;
  localparam logic     SINGLE_CYC  = (LATENCY == 1);
  localparam bit [3:0] COUNT_START = 4'(LATENCY - 1);

  state_t              state;
  logic [3:0]          counter;
  logic [CAP_BITS-1:0] addr_q;
  logic [31:0]         data_q;
  op_t                 op_q;
  logic                done_q;
  logic                misaligned_q;

  logic                req;
  logic                go_resp;
  logic [CAP_BITS-1:0] acc_addr;
  logic [31:0]         acc_data;
  op_t                 acc_op;
  logic                acc_misaligned;
  logic                wr_en;
  logic                rd_en;
  logic [31:0]         rdata;

  // Address bits above the word index are ignored so addresses wrap.
  logic                unused_addr_bits;
  assign unused_addr_bits = ^bus.addr[31:CAP_BITS];

  // go_resp marks the edge that enters RESP. With LATENCY=1 that edge is the
  // same one that captures the request, so the live inputs are used there.
  always_comb begin
    req            = bus.memread | bus.memwrite;
    go_resp        = (state == IDLE && req && SINGLE_CYC) ||
                     (state == BUSY && counter == 4'd1);
    acc_addr       = (state == IDLE) ? bus.addr[CAP_BITS-1:0] : addr_q;
    acc_data       = (state == IDLE) ? bus.write_data : data_q;
    acc_op         = (state == IDLE) ? (bus.memwrite ? OP_WRITE : OP_READ) : op_q;
    acc_misaligned = (acc_addr[OFFSET_BITS-1:0] != '0);
    // A reset on the committing edge discards the pending access.
    wr_en          = go_resp && !rst && (acc_op == OP_WRITE) && !acc_misaligned;
    rd_en          = go_resp && !rst && (acc_op == OP_READ)  && !acc_misaligned;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      counter      <= 4'd0;
      addr_q       <= '0;
      data_q       <= '0;
      op_q         <= OP_READ;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      done_q <= go_resp;
      // misaligned reflects the most recent completed request only.
      if (go_resp) begin
        misaligned_q <= acc_misaligned;
      end
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= bus.addr[CAP_BITS-1:0];
            data_q  <= bus.write_data;
            op_q    <= bus.memwrite ? OP_WRITE : OP_READ;
            counter <= COUNT_START;
            state   <= SINGLE_CYC ? RESP : BUSY;
          end
        end
        // Runs to completion even if the request is withdrawn (flush).
        BUSY: begin
          counter <= counter - 4'd1;
          if (counter == 4'd1) begin
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  d_mem_array #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (32)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .re    (rd_en),
    .idx   (acc_addr[CAP_BITS-1:OFFSET_BITS]),
    .wdata (acc_data),
    .rdata (rdata)
  );

  assign bus.read_data  = rdata;
  assign bus.done       = done_q;
  assign bus.misaligned = misaligned_q;
  assign bus.stall      = (req && state == IDLE) || (state == BUSY);

endmodule
`default_nettype wire

// File: tb/tb_d_mem_resp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_d_mem_resp
//  Purpose  : Self-checking bench for d_mem_resp. One instance at LATENCY=3
//             with a scoreboard of expected completions, one at LATENCY=1.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_d_mem_resp;

  localparam int LAT_A = 3;

  typedef struct packed {
    logic [31:0] data;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  d_mem_resp_if bus_a ();
  d_mem_resp_if bus_b ();

  d_mem_resp #(.ADDR_BITS(8), .LATENCY(LAT_A)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  d_mem_resp #(.ADDR_BITS(8), .LATENCY(1)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sb_q[$];
  logic [31:0] model [256];
  logic [31:0] last_rd = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: each completion pops the oldest expected result.
  always @(negedge clk) begin
    if (!rst && bus_a.done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("read_data", bus_a.read_data, e.data);
        check("misaligned", 32'(bus_a.misaligned), 32'(e.mis));
      end
    end
  end

  // One request on instance A; checks stall/done every cycle. drop_at > 0
  // withdraws the request in that cycle (flush).
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input int drop_at);
    logic [7:0] ix;
    logic       mis;
    exp_t       e;
    ix  = a[9:2];
    mis = (a[1:0] != 2'b00);
    if (wr) begin
      if (!mis) model[ix] = d;
    end else if (!mis) begin
      last_rd = model[ix];
    end
    e.data = last_rd;
    e.mis  = mis;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus_a.memread    = rd;
    bus_a.memwrite   = wr;
    bus_a.addr       = a;
    bus_a.write_data = d;
    for (int c = 0; c <= LAT_A; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == drop_at) begin
          bus_a.memread  = 1'b0;
          bus_a.memwrite = 1'b0;
        end
        // Inputs wiggled while busy must be ignored.
        bus_a.addr       = 32'hFFFF_FFFF;
        bus_a.write_data = 32'h0;
      end
      @(negedge clk);
      check("stall", 32'(bus_a.stall), 32'(c < LAT_A));
      check("done",  32'(bus_a.done),  32'(c == LAT_A));
    end
    bus_a.memread  = 1'b0;
    bus_a.memwrite = 1'b0;
  endtask

  initial begin
    bus_a.memread = 1'b0; bus_a.memwrite = 1'b0; bus_a.addr = '0; bus_a.write_data = '0;
    bus_b.memread = 1'b0; bus_b.memwrite = 1'b0; bus_b.addr = '0; bus_b.write_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_read_data", bus_a.read_data, 32'h0);
    check("rst_done", 32'(bus_a.done), 32'd0);
    check("rst_misaligned", 32'(bus_a.misaligned), 32'd0);
    check("rst_stall", 32'(bus_a.stall), 32'd0);

    // Write then read back, with read_data held afterwards.
    run_txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
    run_txn(1'b1, 1'b0, 32'h10, 32'h0, 0);
    repeat (2) @(negedge clk);
    check("hold_read_data", bus_a.read_data, 32'hDEADBEEF);

    // Both strobes: write wins.
    run_txn(1'b1, 1'b1, 32'h14, 32'h12345678, 0);
    run_txn(1'b1, 1'b0, 32'h14, 32'h0, 0);

    // Misaligned write and read: nothing committed, read_data unchanged.
    run_txn(1'b0, 1'b1, 32'h13, 32'h0BAD0BAD, 0);
    run_txn(1'b1, 1'b0, 32'h11, 32'h0, 0);
    run_txn(1'b1, 1'b0, 32'h10, 32'h0, 0);

    // Address wrap: 0x410 aliases word index 4 (same as 0x10).
    run_txn(1'b0, 1'b1, 32'h410, 32'h0BADF00D, 0);
    run_txn(1'b1, 1'b0, 32'h10, 32'h0, 0);

    // Flush: request dropped during BUSY still commits on time.
    run_txn(1'b0, 1'b1, 32'h30, 32'h5555AAAA, 1);
    run_txn(1'b1, 1'b0, 32'h30, 32'h0, 0);

    // Reset in cycle 1 of a write: old contents survive.
    run_txn(1'b0, 1'b1, 32'h20, 32'h11111111, 0);
    @(posedge clk); #1;
    bus_a.memwrite = 1'b1; bus_a.addr = 32'h20; bus_a.write_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    rst = 1'b1; bus_a.memwrite = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_stall", 32'(bus_a.stall), 32'd0);
    check("midrst_done", 32'(bus_a.done), 32'd0);
    check("midrst_read_data", bus_a.read_data, 32'h0);
    last_rd = 32'h0;
    run_txn(1'b1, 1'b0, 32'h20, 32'h0, 0);

    // LATENCY=1 instance: stall in cycle 0 only, done in cycle 1.
    @(posedge clk); #1;
    bus_b.memwrite = 1'b1; bus_b.addr = 32'h8; bus_b.write_data = 32'hA5A5A5A5;
    @(negedge clk);
    check("l1_wr_stall0", 32'(bus_b.stall), 32'd1);
    check("l1_wr_done0", 32'(bus_b.done), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("l1_wr_stall1", 32'(bus_b.stall), 32'd0);
    check("l1_wr_done1", 32'(bus_b.done), 32'd1);
    bus_b.memwrite = 1'b0;
    @(posedge clk); #1;
    bus_b.memread = 1'b1;
    @(negedge clk);
    check("l1_rd_stall0", 32'(bus_b.stall), 32'd1);
    check("l1_rd_done0", 32'(bus_b.done), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("l1_rd_done1", 32'(bus_b.done), 32'd1);
    check("l1_read_data", bus_b.read_data, 32'hA5A5A5A5);
    bus_b.memread = 1'b0;
    @(negedge clk);
    check("l1_done_pulse", 32'(bus_b.done), 32'd0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
